snitch_icache_event_counter: RTL and testbench

Performance-counter stage directly downstream of the L0 lookup logic. It consumes one icache_events_t vector per fetch port each cycle and accumulates aggregate counts per event type, plus an enabled-cycle counter. Counters are exposed to software through a snapshot/shadow register set and a valid/ready read port. There is no functional effect on fetch.

---
 rtl/snitch_icache_event_counter.sv | 145 ++++++++++++++
 tb/tb_snitch_icache_event_counter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_event_counter.sv
// Aggregates per-port L0 icache events into saturating counters with sticky
// overflow flags, a snapshot shadow set and a single-entry registered read port.
module snitch_icache_event_counter #(
  parameter int unsigned NR_FETCH_PORTS = 4,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH     = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic [NR_FETCH_PORTS*5-1:0] events_i,
  input  logic                        clear_i,
  input  logic                        snapshot_i,
  input  logic                        rd_valid_i,
  output logic                        rd_ready_o,
  input  logic [ADDR_WIDTH-1:0]       rd_addr_i,
  output logic                        rd_rsp_valid_o,
  input  logic                        rd_rsp_ready_i,
  output logic [CNT_WIDTH-1:0]        rd_rsp_data_o,
  output logic                        rd_rsp_err_o
);

  localparam int unsigned NR_CNT    = 6;
  localparam int unsigned CYCLE_IDX = 5;

  logic [CNT_WIDTH-1:0] cnt_r        [NR_CNT];
  logic [CNT_WIDTH-1:0] cnt_nxt_s    [NR_CNT];
  logic [CNT_WIDTH-1:0] shadow_r     [NR_CNT];
  logic                 ovf_r        [NR_CNT];
  logic                 shadow_ovf_r [NR_CNT];
  logic [NR_CNT-1:0]    ovf_set_s;
  logic [NR_CNT-1:0]    shadow_ovf_vec_s;

  logic                 rsp_valid_r;
  logic [CNT_WIDTH-1:0] rsp_data_r;
  logic                 rsp_err_r;
  logic [CNT_WIDTH-1:0] rd_data_s;
  logic                 rd_err_s;
  logic                 accept_s;

  // Number of ports asserting event bit bit_idx, widened for the saturation sum.
  function automatic logic [CNT_WIDTH:0] popcount(
    input logic [NR_FETCH_PORTS*5-1:0] ev,
    input int unsigned                 bit_idx
  );
    logic [CNT_WIDTH:0]          acc;
    logic [NR_FETCH_PORTS*5-1:0] sh;
    acc = '0;
    for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
      sh  = ev >> (5 * p + bit_idx);
      acc = acc + {{CNT_WIDTH{1'b0}}, sh[0]};
    end
    return acc;
  endfunction

  for (genvar g = 0; g < NR_CNT; g++) begin : gen_cnt
    logic [CNT_WIDTH:0] inc_s;
    logic [CNT_WIDTH:0] sum_s;

    // Counter e maps to event bit 4-e (miss is the MSB of each port slice).
    if (g == CYCLE_IDX) begin : gen_cycle
      assign inc_s = {{CNT_WIDTH{1'b0}}, 1'b1};
    end else begin : gen_event
      assign inc_s = popcount(events_i, 4 - g);
    end

    assign sum_s               = {1'b0, cnt_r[g]} + inc_s;
    assign ovf_set_s[g]        = sum_s[CNT_WIDTH];
    assign cnt_nxt_s[g]        = sum_s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum_s[CNT_WIDTH-1:0];
    assign shadow_ovf_vec_s[g] = shadow_ovf_r[g];

    // Live counter with clear priority and sticky overflow; shadow captures pre-update value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_r[g]        <= '0;
        ovf_r[g]        <= 1'b0;
        shadow_r[g]     <= '0;
        shadow_ovf_r[g] <= 1'b0;
      end else begin
        if (snapshot_i) begin
          shadow_r[g]     <= cnt_r[g];
          shadow_ovf_r[g] <= ovf_r[g];
        end else begin
          shadow_r[g]     <= shadow_r[g];
          shadow_ovf_r[g] <= shadow_ovf_r[g];
        end
        if (clear_i) begin
          cnt_r[g] <= '0;
          ovf_r[g] <= 1'b0;
        end else if (enable_i) begin
          cnt_r[g] <= cnt_nxt_s[g];
          ovf_r[g] <= ovf_r[g] | ovf_set_s[g];
        end else begin
          cnt_r[g] <= cnt_r[g];
          ovf_r[g] <= ovf_r[g];
        end
      end
    end
  end

  // Shadow register read mux; anything past the flag word is an error.
  always_comb begin
    rd_data_s = '0;
    rd_err_s  = 1'b0;
    case (rd_addr_i)
      ADDR_WIDTH'(0): rd_data_s = shadow_r[0];
      ADDR_WIDTH'(1): rd_data_s = shadow_r[1];
      ADDR_WIDTH'(2): rd_data_s = shadow_r[2];
      ADDR_WIDTH'(3): rd_data_s = shadow_r[3];
      ADDR_WIDTH'(4): rd_data_s = shadow_r[4];
      ADDR_WIDTH'(5): rd_data_s = shadow_r[5];
      ADDR_WIDTH'(6): rd_data_s = {{(CNT_WIDTH-NR_CNT){1'b0}}, shadow_ovf_vec_s};
      default:        rd_err_s  = 1'b1;
    endcase
  end

  assign rd_ready_o = !rsp_valid_r | rd_rsp_ready_i;
  assign accept_s   = rd_valid_i & rd_ready_o;

  // Single-entry response register; held stable until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= rd_data_s;
      rsp_err_r   <= rd_err_s;
    end else if (rd_rsp_ready_i) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= rsp_data_r;
      rsp_err_r   <= rsp_err_r;
    end else begin
      rsp_valid_r <= rsp_valid_r;
      rsp_data_r  <= rsp_data_r;
      rsp_err_r   <= rsp_err_r;
    end
  end

  assign rd_rsp_valid_o = rsp_valid_r;
  assign rd_rsp_data_o  = rsp_data_r;
  assign rd_rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_snitch_icache_event_counter.sv
// Directed bench: a 32-bit and an 8-bit counter instance share all stimulus.
module tb_snitch_icache_event_counter;

  localparam logic [19:0] EV_MH = {5'b01000, 5'b11000, 5'b01000, 5'b11000};
  localparam logic [19:0] EV_H  = {4{5'b01000}};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [19:0] events = 20'd0;
  logic        clear = 1'b0;
  logic        snapshot = 1'b0;
  logic        rd_valid = 1'b0;
  logic [2:0]  rd_addr = 3'd0;
  logic        rd_rsp_ready = 1'b1;

  logic        rdy32, vld32, err32;
  logic [31:0] d32;
  logic        rdy8, vld8, err8;
  logic [7:0]  d8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snitch_icache_event_counter #(.NR_FETCH_PORTS(4), .CNT_WIDTH(32), .ADDR_WIDTH(3)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .events_i(events),
    .clear_i(clear), .snapshot_i(snapshot), .rd_valid_i(rd_valid), .rd_ready_o(rdy32),
    .rd_addr_i(rd_addr), .rd_rsp_valid_o(vld32), .rd_rsp_ready_i(rd_rsp_ready),
    .rd_rsp_data_o(d32), .rd_rsp_err_o(err32)
  );

  snitch_icache_event_counter #(.NR_FETCH_PORTS(4), .CNT_WIDTH(8), .ADDR_WIDTH(3)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .events_i(events),
    .clear_i(clear), .snapshot_i(snapshot), .rd_valid_i(rd_valid), .rd_ready_o(rdy8),
    .rd_addr_i(rd_addr), .rd_rsp_valid_o(vld8), .rd_rsp_ready_i(rd_rsp_ready),
    .rd_rsp_data_o(d8), .rd_rsp_err_o(err8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One read with the consumer ready; response checked the cycle after acceptance.
  task automatic rd(input logic [2:0] a, input logic [63:0] exp32, input logic [63:0] exp8,
                    input logic exp_err, input string tag);
    @(negedge clk);
    rd_valid = 1'b1;
    rd_addr = a;
    rd_rsp_ready = 1'b1;
    chk({tag, "_idle"}, {vld8, vld32, rdy8, rdy32}, 64'h3);
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_vld"}, {vld8, vld32}, 64'h3);
    chk({tag, "_d32"}, d32, exp32);
    chk({tag, "_d8"}, d8, exp8);
    chk({tag, "_err"}, {err8, err32}, exp_err ? 64'h3 : 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", {vld8, vld32}, 64'h0);
    chk("rst_data", {d8, d32}, 64'h0);
    chk("rst_err", {err8, err32}, 64'h0);
    chk("rst_rdy", {rdy8, rdy32}, 64'h3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 7; a++) rd(3'(a), 64'd0, 64'd0, 1'b0, "rst_rd");

    // 10 enabled cycles: miss on ports 0,2, hit on all ports
    @(negedge clk);
    events = EV_MH;
    enable = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    events = 20'd0;
    snapshot = 1'b1;
    @(negedge clk);
    snapshot = 1'b0;
    rd(3'd0, 64'd20, 64'd20, 1'b0, "mh_miss");
    rd(3'd1, 64'd40, 64'd40, 1'b0, "mh_hit");
    rd(3'd2, 64'd0, 64'd0, 1'b0, "mh_pref");
    rd(3'd3, 64'd0, 64'd0, 1'b0, "mh_dbl");
    rd(3'd4, 64'd0, 64'd0, 1'b0, "mh_stall");
    rd(3'd5, 64'd10, 64'd10, 1'b0, "mh_cyc");

    // Clear beats a same-cycle increment; enable low for cycles 3..5
    @(negedge clk);
    clear = 1'b1;
    enable = 1'b1;
    events = EV_MH;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      clear = 1'b0;
      enable = (i < 3 || i > 5);
    end
    // Snapshot with enable high must exclude this cycle's increment
    @(negedge clk);
    enable = 1'b1;
    snapshot = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    events = 20'd0;
    snapshot = 1'b0;
    rd(3'd0, 64'd14, 64'd14, 1'b0, "gap_miss");
    rd(3'd1, 64'd28, 64'd28, 1'b0, "gap_hit");
    rd(3'd5, 64'd7, 64'd7, 1'b0, "gap_cyc");
    rd(3'd6, 64'd0, 64'd0, 1'b0, "gap_flags");

    // 70 cycles of 4 hits: 8-bit hit counter saturates at 255
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    events = EV_H;
    enable = 1'b1;
    repeat (70) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    events = 20'd0;
    snapshot = 1'b1;
    @(negedge clk);
    snapshot = 1'b0;
    rd(3'd1, 64'd280, 64'd255, 1'b0, "sat_hit");
    rd(3'd5, 64'd70, 64'd70, 1'b0, "sat_cyc");
    rd(3'd6, 64'd0, 64'd2, 1'b0, "sat_flags");
    @(negedge clk);
    clear = 1'b1;
    snapshot = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    snapshot = 1'b0;
    rd(3'd1, 64'd280, 64'd255, 1'b0, "clrsnap_hit");
    rd(3'd6, 64'd0, 64'd2, 1'b0, "clrsnap_flags");
    @(negedge clk);
    snapshot = 1'b1;
    @(negedge clk);
    snapshot = 1'b0;
    rd(3'd1, 64'd0, 64'd0, 1'b0, "post_clr_hit");
    rd(3'd6, 64'd0, 64'd0, 1'b0, "post_clr_flags");

    // Backpressure: shadow cycle=3, live cycle=5
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    snapshot = 1'b1;
    @(negedge clk);
    snapshot = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    rd_valid = 1'b1;
    rd_addr = 3'd5;
    rd_rsp_ready = 1'b0;
    chk("bp_rdy_first", {rdy8, rdy32}, 64'h3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_vld", {vld8, vld32}, 64'h3);
      chk("bp_d32", d32, 64'd3);
      chk("bp_d8", d8, 64'd3);
      chk("bp_rdy", {rdy8, rdy32}, 64'h0);
      snapshot = (k == 1);
    end
    rd_rsp_ready = 1'b1;
    #1;
    chk("bp_rdy_release", {rdy8, rdy32}, 64'h3);
    @(negedge clk);
    rd_valid = 1'b0;
    chk("bp_second_vld", {vld8, vld32}, 64'h3);
    chk("bp_second_d32", d32, 64'd5);
    chk("bp_second_d8", d8, 64'd5);
    @(negedge clk);
    chk("bp_drained", {vld8, vld32}, 64'h0);

    // Out-of-range then back-to-back reads, one response per cycle
    @(negedge clk);
    rd_valid = 1'b1;
    rd_addr = 3'd7;
    rd_rsp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_oor_vld", {vld8, vld32}, 64'h3);
    chk("b2b_oor_data", {d8, d32}, 64'h0);
    chk("b2b_oor_err", {err8, err32}, 64'h3);
    chk("b2b_rdy", {rdy8, rdy32}, 64'h3);
    rd_addr = 3'd5;
    @(negedge clk);
    chk("b2b_cyc_vld", {vld8, vld32}, 64'h3);
    chk("b2b_cyc_d32", d32, 64'd5);
    chk("b2b_cyc_err", {err8, err32}, 64'h0);
    rd_addr = 3'd6;
    @(negedge clk);
    rd_valid = 1'b0;
    chk("b2b_flags_vld", {vld8, vld32}, 64'h3);
    chk("b2b_flags_data", {d8, d32}, 64'h0);
    chk("b2b_flags_err", {err8, err32}, 64'h0);
    @(negedge clk);
    chk("b2b_drained", {vld8, vld32}, 64'h0);

    // Asynchronous reset drops a pending response
    rd_valid = 1'b1;
    rd_addr = 3'd5;
    rd_rsp_ready = 1'b0;
    @(negedge clk);
    rd_valid = 1'b0;
    chk("ar_pending", {vld8, vld32}, 64'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", {vld8, vld32}, 64'h0);
    chk("ar_data", {d8, d32}, 64'h0);
    chk("ar_rdy", {rdy8, rdy32}, 64'h3);
    @(negedge clk);
    rst_n = 1'b1;
    rd_rsp_ready = 1'b1;
    rd(3'd5, 64'd0, 64'd0, 1'b0, "ar_shadow");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
